// File: rtl/m72_pkg.sv
// Shared constants for the M72 sound command path: Z80 RST vector masks and I/O port numbers.
package m72_pkg;

    localparam logic [7:0] SND_VEC_IDLE     = 8'hFF;
    localparam logic [7:0] SND_VEC_YM_MASK  = 8'hEF;
    localparam logic [7:0] SND_VEC_CMD_MASK = 8'hDF;

    localparam logic [7:0] SND_CMD_PORT_WR  = 8'h00;
    localparam logic [7:0] SND_Z80_PORT_RD  = 8'h02;
    localparam logic [7:0] SND_Z80_PORT_ACK = 8'h06;

    // Each active source clears its own bit of the idle RST FF; both together give RST 08h (CF).
    function automatic logic [7:0] snd_vec_merge(input logic ym_active, input logic cmd_pending);
        logic [7:0] vec;
        vec = SND_VEC_IDLE;
        if (ym_active)   vec = vec & SND_VEC_YM_MASK;
        if (cmd_pending) vec = vec & SND_VEC_CMD_MASK;
        return vec;
    endfunction

endpackage

// File: rtl/sound_cmd_if.sv
// Main-CPU / sound-Z80 command handshake bundle. The slave modport is the latch end.
interface sound_cmd_if;

    logic       main_wr;
    logic [7:0] main_din;
    logic       main_pending;
    logic       snd_ack;
    logic [7:0] snd_dout;
    logic       ym_irq_n;
    logic       z80_int_n;
    logic [7:0] z80_int_vector;
    logic       overflow;

    modport slave (
        input  main_wr, main_din, snd_ack, ym_irq_n,
        output main_pending, snd_dout, z80_int_n, z80_int_vector, overflow
    );

    modport master (
        output main_wr, main_din, snd_ack, ym_irq_n,
        input  main_pending, snd_dout, z80_int_n, z80_int_vector, overflow
    );

endinterface

// File: rtl/sound_cmd_fifo.sv
// Small synchronous FIFO for queued sound commands; DEPTH must be a power of two so pointers wrap freely.
module sound_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A pop frees the slot in the same edge, so a push at full still lands when paired with one.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sound_cmd_latch.sv
// Sound command latch: main V30 writes a byte, Z80 gets an RST interrupt merged with YM2151 IRQ.
// Define SOUND_CMD_FIFO_EN to replace the single latch with a FIFO_DEPTH-entry queue.
module sound_cmd_latch #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         CLK_32M,
    input  logic         reset,
    sound_cmd_if.slave   bus
);

    import m72_pkg::*;

    generate
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sound_cmd_latch: FIFO_DEPTH must be a power of two in 2..16");
        end
    endgenerate

    logic       wr_q, wr_d, wr_prev_q, wr_prev_d;
    logic       ack_q, ack_d, ack_prev_q, ack_prev_d;
    logic [7:0] din_q, din_d;
    logic       ym_q, ym_d;
    logic [7:0] vec_q, vec_d;
    logic       int_n_q, int_n_d;
    logic       wr_ev, ack_ev;
    logic       cmd_pending;
    logic [7:0] cmd_dout;

    // Bus strobes are multi-cycle levels; one registered rising edge per write/ack.
    always_comb begin
        wr_d       = bus.main_wr;
        wr_prev_d  = wr_q;
        ack_d      = bus.snd_ack;
        ack_prev_d = ack_q;
        din_d      = bus.main_din;
        ym_d       = bus.ym_irq_n;
    end

    assign wr_ev  = wr_q & ~wr_prev_q;
    assign ack_ev = ack_q & ~ack_prev_q;

`ifdef SOUND_CMD_FIFO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [7:0]    last_q, last_d;
    logic          overflow_q, overflow_d;

    sound_cmd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (CLK_32M),
        .rst   (reset),
        .push  (wr_ev),
        .pop   (ack_ev),
        .din   (din_q),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Once drained, the Z80 keeps seeing the last byte it consumed rather than a stale slot.
    always_comb begin
        last_d     = last_q;
        overflow_d = overflow_q;
        if (ack_ev && !fifo_empty)             last_d     = fifo_head;
        if (wr_ev && fifo_full && !ack_ev)     overflow_d = 1'b1;
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            last_q     <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign cmd_pending  = (fifo_count != '0);
    assign cmd_dout     = fifo_empty ? last_q : fifo_head;
    assign bus.overflow = overflow_q;
`else
    logic [7:0] latch_q, latch_d;
    logic       pending_q, pending_d;

    // Write beats ack on a shared edge so a fresh command is never lost.
    always_comb begin
        latch_d   = latch_q;
        pending_d = pending_q;
        if (ack_ev) pending_d = 1'b0;
        if (wr_ev) begin
            latch_d   = din_q;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            latch_q   <= 8'h00;
            pending_q <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            pending_q <= pending_d;
        end
    end

    assign cmd_pending  = pending_q;
    assign cmd_dout     = latch_q;
    assign bus.overflow = 1'b0;
`endif

    always_comb begin
        vec_d   = snd_vec_merge(~ym_q, cmd_pending);
        int_n_d = (vec_d == SND_VEC_IDLE);
    end

    // ym_q resets to the inactive level so INT stays off until the YM line is really sampled.
    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            wr_q       <= 1'b0;
            wr_prev_q  <= 1'b0;
            ack_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            din_q      <= 8'h00;
            ym_q       <= 1'b1;
            vec_q      <= SND_VEC_IDLE;
            int_n_q    <= 1'b1;
        end else begin
            wr_q       <= wr_d;
            wr_prev_q  <= wr_prev_d;
            ack_q      <= ack_d;
            ack_prev_q <= ack_prev_d;
            din_q      <= din_d;
            ym_q       <= ym_d;
            vec_q      <= vec_d;
            int_n_q    <= int_n_d;
        end
    end

    assign bus.main_pending   = cmd_pending;
    assign bus.snd_dout       = cmd_dout;
    assign bus.z80_int_n      = int_n_q;
    assign bus.z80_int_vector = vec_q;

endmodule

// File: tb/tb_sound_cmd_latch.sv
// Directed bench for sound_cmd_latch: handshake, interrupt merge, collision and (with SOUND_CMD_FIFO_EN) FIFO cases.
module tb_sound_cmd_latch;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    sound_cmd_if bus ();

    sound_cmd_latch #(.FIFO_DEPTH(4)) dut (
        .CLK_32M (clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_wr(input logic [7:0] d, input int hold);
        bus.main_din = d;
        bus.main_wr  = 1'b1;
        tick(hold);
        bus.main_wr  = 1'b0;
        tick(3);
    endtask

    task automatic do_ack(input int hold);
        bus.snd_ack = 1'b1;
        tick(hold);
        bus.snd_ack = 1'b0;
        tick(3);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        vec_cnt      = 0;
        err_cnt      = 0;
        rst          = 1'b1;
        bus.main_wr  = 1'b0;
        bus.main_din = 8'h00;
        bus.snd_ack  = 1'b0;
        bus.ym_irq_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        chk("rst_pending", {7'd0, bus.main_pending}, 8'h00);
        chk("rst_dout",    bus.snd_dout,             8'h00);
        chk("rst_int_n",   {7'd0, bus.z80_int_n},    8'h01);
        chk("rst_vec",     bus.z80_int_vector,       8'hFF);
        chk("rst_ovf",     {7'd0, bus.overflow},     8'h00);

        // Handshake with latency and held-level checks
        bus.main_din = 8'h3C;
        bus.main_wr  = 1'b1;
        tick(1);
        chk("hs_pend_e1",  {7'd0, bus.main_pending}, 8'h00);
        tick(1);
        chk("hs_pend_e2",  {7'd0, bus.main_pending}, 8'h01);
        chk("hs_dout_e2",  bus.snd_dout,             8'h3C);
        chk("hs_int_e2",   {7'd0, bus.z80_int_n},    8'h01);
        tick(1);
        chk("hs_int_e3",   {7'd0, bus.z80_int_n},    8'h00);
        chk("hs_vec_e3",   bus.z80_int_vector,       8'hDF);
        bus.main_din = 8'h99;
        tick(3);
        bus.main_wr = 1'b0;
        tick(3);
        chk("hs_hold_dout", bus.snd_dout,             8'h3C);
        chk("hs_hold_pend", {7'd0, bus.main_pending}, 8'h01);
        bus.snd_ack = 1'b1;
        tick(2);
        chk("hs_ack_pend", {7'd0, bus.main_pending}, 8'h00);
        chk("hs_ack_int_lag", {7'd0, bus.z80_int_n}, 8'h00);
        tick(1);
        chk("hs_ack_vec",  bus.z80_int_vector,       8'hFF);
        chk("hs_ack_int",  {7'd0, bus.z80_int_n},    8'h01);
        chk("hs_ack_dout", bus.snd_dout,             8'h3C);
        tick(2);
        bus.snd_ack = 1'b0;
        tick(2);

        // Interrupt merge
        bus.ym_irq_n = 1'b0;
        tick(1);
        chk("ym_lat1", bus.z80_int_vector, 8'hFF);
        tick(1);
        chk("ym_lat2", bus.z80_int_vector, 8'hEF);
        do_wr(8'h77, 3);
        chk("mrg_both", bus.z80_int_vector, 8'hCF);
        chk("mrg_int",  {7'd0, bus.z80_int_n}, 8'h00);
        do_ack(3);
        chk("mrg_ym_only", bus.z80_int_vector, 8'hEF);
        bus.ym_irq_n = 1'b1;
        tick(2);
        chk("mrg_idle_vec", bus.z80_int_vector, 8'hFF);
        chk("mrg_idle_int", {7'd0, bus.z80_int_n}, 8'h01);

        // Asynchronous reset while pending with YM active
        do_wr(8'h55, 3);
        bus.ym_irq_n = 1'b0;
        tick(2);
        chk("ar_pre_vec", bus.z80_int_vector, 8'hCF);
        rst = 1'b1;
        #1;
        chk("ar_int_n",   {7'd0, bus.z80_int_n},    8'h01);
        chk("ar_vec",     bus.z80_int_vector,       8'hFF);
        chk("ar_pending", {7'd0, bus.main_pending}, 8'h00);
        chk("ar_dout",    bus.snd_dout,             8'h00);
        tick(2);
        rst = 1'b0;
        #1;
        chk("ar_rel_vec", bus.z80_int_vector, 8'hFF);
        tick(1);
        chk("ar_rel_e1",  bus.z80_int_vector, 8'hFF);
        tick(1);
        chk("ar_rel_e2",  bus.z80_int_vector, 8'hEF);
        bus.ym_irq_n = 1'b1;
        tick(3);

`ifndef SOUND_CMD_FIFO_EN
        // Overwrite and write/ack collision
        do_wr(8'h11, 2);
        chk("col_first", bus.snd_dout, 8'h11);
        bus.main_din = 8'h22;
        bus.main_wr  = 1'b1;
        bus.snd_ack  = 1'b1;
        tick(2);
        chk("col_dout", bus.snd_dout,             8'h22);
        chk("col_pend", {7'd0, bus.main_pending}, 8'h01);
        tick(3);
        bus.main_wr = 1'b0;
        bus.snd_ack = 1'b0;
        tick(3);
        chk("col_hold_pend", {7'd0, bus.main_pending}, 8'h01);
        chk("col_vec",       bus.z80_int_vector,       8'hDF);
        do_wr(8'h33, 2);
        chk("ovw_dout", bus.snd_dout,         8'h33);
        chk("ovw_ovf",  {7'd0, bus.overflow}, 8'h00);
        do_ack(2);
        chk("ovw_clear", {7'd0, bus.main_pending}, 8'h00);
`else
        // FIFO fill past full, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) do_wr(8'(i), 2);
        chk("ff_ovf",  {7'd0, bus.overflow},     8'h01);
        chk("ff_pend", {7'd0, bus.main_pending}, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            chk("ff_head", bus.snd_dout, 8'(i));
            do_ack(2);
        end
        chk("ff_empty_pend", {7'd0, bus.main_pending}, 8'h00);
        chk("ff_empty_dout", bus.snd_dout,             8'h04);
        do_ack(2);
        chk("ff_extra_pend", {7'd0, bus.main_pending}, 8'h00);
        chk("ff_extra_dout", bus.snd_dout,             8'h04);

        // Simultaneous push and pop at full
        do_reset();
        do_wr(8'h10, 2);
        do_wr(8'h20, 2);
        do_wr(8'h30, 2);
        do_wr(8'h40, 2);
        chk("fp_full_ovf", {7'd0, bus.overflow}, 8'h00);
        bus.main_din = 8'hAA;
        bus.main_wr  = 1'b1;
        bus.snd_ack  = 1'b1;
        tick(2);
        bus.main_wr = 1'b0;
        bus.snd_ack = 1'b0;
        tick(3);
        chk("fp_head", bus.snd_dout,         8'h20);
        chk("fp_ovf",  {7'd0, bus.overflow}, 8'h00);
        do_ack(2);
        chk("fp_d30", bus.snd_dout, 8'h30);
        do_ack(2);
        chk("fp_d40", bus.snd_dout, 8'h40);
        do_ack(2);
        chk("fp_dAA", bus.snd_dout, 8'hAA);
        chk("fp_pend_last", {7'd0, bus.main_pending}, 8'h01);
        do_ack(2);
        chk("fp_drained", {7'd0, bus.main_pending}, 8'h00);
        chk("fp_held",    bus.snd_dout,             8'hAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sound_cmd_latch.md
Name: sound_cmd_latch

Overview:
- Responder end of the main-CPU-to-sound-CPU command path.
- Captures bytes the main V30 writes to I/O port 0x00 (the SND strobe from the main I/O decoder).
- Holds each byte for the sound Z80 and raises the Z80 interrupt, merged with the YM2151 IRQ.
- Clears the command interrupt when the Z80 acknowledges it through its port-0x06 write.

Parameters:
- FIFO_DEPTH, 4, number of command entries when SOUND_CMD_FIFO_EN is defined; power of two, 2..16; ignored otherwise.

Ports:
- CLK_32M  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- main_wr  in  1  main-side SND decode (IOWR & port 0x00); a level held for several cycles per bus write.
- main_din  in  8  main CPU data bus, low byte; valid while main_wr is high.
- main_pending  out  1  high while any command is unacknowledged.
- snd_ack  in  1  Z80 port-0x06 write decode; a level held for several cycles.
- snd_dout  out  8  current command byte, read by the Z80 on port 0x02.
- ym_irq_n  in  1  YM2151 IRQ, active low, synchronous to CLK_32M.
- z80_int_n  out  1  Z80 INT, active low.
- z80_int_vector  out  8  mode-0 RST opcode driven during interrupt acknowledge.
- overflow  out  1  sticky: a write was dropped because the FIFO was full. Constant 0 without the FIFO.

Behaviour:
- Reset (asynchronous, immediate) drives all outputs and state to their reset values:
  - main_pending=0, snd_dout=8'h00, overflow=0.
  - z80_int_n=1, z80_int_vector=8'hFF.
  - Edge-detect history registers=0, FIFO pointers and count=0.
- Strobe qualification:
  - main_wr and snd_ack are level inputs. Each is registered once, and only its rising edge (current=1, previous=0) produces one event.
  - A held level never repeats an event.
- Single-latch mode (no macro):
  - Write event at edge N: at N+1, latch=main_din and pending=1. Overwrite while pending is allowed, with no error.
  - Ack event at edge N: pending=0 at N+1. The latch value is retained.
  - Write and ack events on the same edge: the write wins, so pending stays 1 and the latch takes the new byte.
- Reading snd_dout has no side effect; only an ack clears.
- Output registers:
  - snd_dout is the latch, or the FIFO head.
  - main_pending is the pending flag, or !empty in FIFO mode.
- Vector and interrupt, computed combinationally from the pending flag and a registered copy of ym_irq_n, then registered:
  - Start from 8'hFF.
  - If ym_irq_n was low, AND the vector with 8'hEF (RST 28h).
  - If pending, AND the vector with 8'hDF (RST 18h).
  - Both sources active gives 8'hCF.
  - z80_int_n = (vector == 8'hFF).
- Latencies:
  - Write edge to z80_int_n low: 2 cycles after the main_wr rise is sampled. The pending flag updates first, then the vector/INT register.
  - ym_irq_n change to INT: 2 cycles.
- The interrupt-acknowledge cycle itself does not clear anything; clearing happens only through snd_ack.

Optional Feature:
- Macro: SOUND_CMD_FIFO_EN.
- When defined, the latch becomes a FIFO of FIFO_DEPTH bytes:
  - A write event pushes main_din.
  - An ack event pops the head.
  - snd_dout is the head entry, or the last popped value when empty; the value is held.
  - pending = count != 0.
  - Push while full and without a simultaneous pop drops the byte and sets overflow=1. overflow clears only on reset.
  - Simultaneous push and pop: both happen and count is unchanged, including at full.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- When undefined: the single-latch behaviour above, overflow tied to 0, and no FIFO storage is synthesised.

Decomposition:
- m72_pkg holds these constants:
  - SND_VEC_IDLE = 8'hFF
  - SND_VEC_YM_MASK = 8'hEF
  - SND_VEC_CMD_MASK = 8'hDF
  - SND_CMD_PORT_WR = 8'h00
  - SND_Z80_PORT_RD = 8'h02
  - SND_Z80_PORT_ACK = 8'h06
- One sub-module, sound_cmd_fifo: a parameterised synchronous FIFO with push, pop, head, count, full and empty. It is instantiated only under SOUND_CMD_FIFO_EN.
- The edge detectors and the vector logic stay inline.

Test Plan:
1. Reset: assert reset mid-pending with ym_irq_n low -> outputs go to reset values immediately (z80_int_n=1, vector 8'hFF, main_pending=0). After release they stay there until ym_irq_n is resampled.
2. Command handshake: main_wr high for 6 cycles with din=8'h3C, then wait -> exactly one event. snd_dout=8'h3C, main_pending=1, vector=8'hDF, z80_int_n low 2 cycles after the rise. snd_ack pulse -> pending=0, vector=8'hFF, snd_dout still 8'h3C.
3. Interrupt merge: ym_irq_n low plus command pending -> vector 8'hCF. Ack the command -> 8'hEF. Release ym_irq_n -> 8'hFF and z80_int_n=1.
4. Collision and overwrite (no macro): write 8'h11, then write 8'h22 on the same cycle as an ack edge -> snd_dout=8'h22 and main_pending stays 1.
5. FIFO mode, FIFO_DEPTH=4: five writes 8'h01..8'h05 with no ack -> the fifth is dropped and overflow=1. Four acks -> snd_dout reads 01, 02, 03, 04, then main_pending=0. A fifth ack -> no change.
6. FIFO full with simultaneous push and pop: at count=4, write 8'hAA on the same edge as an ack -> count stays 4, head advances, 8'hAA is stored last, and overflow is unchanged.
